// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_write_arbiter
//  Purpose  : Round-robin burst arbiter sharing one async-FIFO write port.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA      = 6,
    parameter int BURST     = 4,
    parameter int STALL_MAX = 8
) (
    input  logic                   wclk,
    input  logic                   wrst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA-1:0]   req_data,
    input  logic                   w_full,
    input  logic                   almost_full,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        ack,
    output logic                   w_en,
    output logic [DATA-1:0]        wdata,
    output logic                   busy,
    output logic                   stall_timeout
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(BURST) + 1;
    localparam int CW = $clog2(STALL_MAX) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    localparam logic [BW-1:0] C_BEAT_LAST  = BW'(BURST - 1);
    localparam logic [CW-1:0] C_STALL_LAST = CW'(STALL_MAX);

    logic [1:0]      state_q,   state_d;
    logic [NREQ-1:0] grant_q,   grant_d;
    logic [SW-1:0]   sel_q,     sel_d;
    logic [SW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [BW-1:0]   beat_q,    beat_d;
    logic [CW-1:0]   stall_q,   stall_d;
    logic            timeout_q, timeout_d;

    logic            w_req_sel;
    logic            w_write;
    logic [SW-1:0]   w_pick;
    logic [SW-1:0]   w_ptr_next;

    // grant_q is one-hot of sel_q while busy, so masking avoids a variable index
    assign w_req_sel  = |(req & grant_q);
    assign w_write    = (state_q == S_BURST) & w_req_sel & ~w_full;
    assign w_ptr_next = (sel_q == SW'(NREQ - 1)) ? '0 : sel_q + 1'b1;

    // First requester at or after rr_ptr, measured as rotational distance
    always_comb begin
        int v_best;
        int v_dist;
        w_pick = '0;
        v_best = NREQ;
        v_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            v_dist = i - int'(rr_ptr_q);
            if (v_dist < 0) v_dist = v_dist + NREQ;
            if (req[i] && (v_dist < v_best)) begin
                v_best = v_dist;
                w_pick = SW'(i);
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            beat_q    <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            beat_q    <= beat_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        beat_d    = beat_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((|req) && !almost_full) begin
                    state_d = S_BURST;
                    sel_d   = w_pick;
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                    beat_d  = '0;
                end
            end
            S_BURST: begin
                if (!w_req_sel || (!w_full && (beat_q == C_BEAT_LAST))) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = w_ptr_next;
                end else if (w_full) begin
                    state_d = S_STALL;
                    stall_d = CW'(1);
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_STALL: begin
                if (!w_req_sel) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = w_ptr_next;
                end else if (!w_full) begin
                    state_d = S_BURST;
                end else if (stall_q == C_STALL_LAST) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = w_ptr_next;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        w_en  = w_write;
        ack   = w_write ? grant_q : '0;
        wdata = '0;
        if (state_q == S_BURST) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_q[i]) wdata = req_data[i*DATA +: DATA];
            end
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q != S_IDLE);
    assign stall_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_write_arbiter
//  Purpose  : Randomized self-checking bench against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int NREQ      = 4;
    localparam int DATA      = 6;
    localparam int BURST     = 4;
    localparam int STALL_MAX = 8;
    localparam int NCYC      = 2400;

    logic                 wclk = 1'b0;
    logic                 wrst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DATA-1:0] req_data;
    logic                 w_full;
    logic                 almost_full;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      ack;
    logic                 w_en;
    logic [DATA-1:0]      wdata;
    logic                 busy;
    logic                 stall_timeout;

    fifo_write_arbiter #(
        .NREQ(NREQ), .DATA(DATA), .BURST(BURST), .STALL_MAX(STALL_MAX)
    ) dut (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data),
        .w_full(w_full), .almost_full(almost_full), .grant(grant), .ack(ack),
        .w_en(w_en), .wdata(wdata), .busy(busy), .stall_timeout(stall_timeout)
    );

    always #5 wclk = ~wclk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 writing, 2 waiting on full
    int m_phase, m_owner, m_ptr, m_writes, m_full_run;
    bit m_pulse;

    logic [NREQ-1:0] e_grant, e_ack, prev_ack;
    logic            e_wen;
    logic [DATA-1:0] e_wdata;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_writes = 0; m_full_run = 0; m_pulse = 0;
    endtask

    task automatic model_expect();
        logic [NREQ*DATA-1:0] sh;
        e_grant = (m_phase != 0) ? NREQ'(1 << m_owner) : '0;
        e_wen   = (m_phase == 1) && req[m_owner] && !w_full;
        e_ack   = e_wen ? e_grant : '0;
        sh      = req_data >> (m_owner * DATA);
        e_wdata = (m_phase == 1) ? sh[DATA-1:0] : '0;
    endtask

    task automatic model_release();
        m_phase = 0;
        m_ptr   = (m_owner + 1) % NREQ;
    endtask

    task automatic model_step();
        m_pulse = 0;
        if (m_phase == 0) begin
            if (req != 0 && !almost_full) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_phase == 0 && req[(m_ptr + k) % NREQ]) begin
                        m_owner  = (m_ptr + k) % NREQ;
                        m_phase  = 1;
                        m_writes = 0;
                    end
                end
            end
        end else if (!req[m_owner]) begin
            model_release();
        end else if (m_phase == 1) begin
            if (w_full) begin
                m_phase    = 2;
                m_full_run = 1;
            end else begin
                m_writes++;
                if (m_writes == BURST) model_release();
            end
        end else begin
            if (!w_full) m_phase = 1;
            else if (m_full_run == STALL_MAX) begin
                m_pulse = 1;
                model_release();
            end else m_full_run++;
        end
    endtask

    task automatic check_all(input string where);
        model_expect();
        chk({where, ".grant"}, 32'(grant), 32'(e_grant));
        chk({where, ".ack"},   32'(ack),   32'(e_ack));
        chk({where, ".w_en"},  32'(w_en),  32'(e_wen));
        chk({where, ".wdata"}, 32'(wdata), 32'(e_wdata));
        chk({where, ".busy"},  32'(busy),  32'(m_phase != 0));
        chk({where, ".tmo"},   32'(stall_timeout), 32'(m_pulse));
        chk({where, ".ovf"},   32'(w_en & w_full), 32'(0));
    endtask

    int full_left = 0;

    task automatic drive(input int cyc);
        for (int i = 0; i < NREQ; i++) begin
            if (prev_ack[i] || !req[i]) req_data[i*DATA +: DATA] = DATA'($urandom);
        end
        almost_full = 1'b0;
        w_full      = 1'b0;
        if (cyc < 40) begin
            req = 4'b0100;
        end else if (cyc < 140) begin
            req = 4'b1111;
        end else if (cyc < 240) begin
            req    = 4'b1111;
            w_full = ((cyc % 23) >= 5 && (cyc % 23) <= 7) || ((cyc % 23) >= 12 && (cyc % 23) <= 21);
            almost_full = (cyc % 31) < 4;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (prev_ack[i] && ($urandom % 4 == 0)) req[i] = 1'b0;
                    else if ($urandom % 24 == 0) req[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    req[i] = 1'b1;
                end
            end
            if (full_left > 0) begin
                full_left--;
                w_full = 1'b1;
            end else if ($urandom % 40 == 0) begin
                full_left = $urandom_range(1, 14);
                w_full    = 1'b1;
            end else begin
                w_full = ($urandom % 8 == 0);
            end
            almost_full = w_full ? ($urandom % 2 == 0) : ($urandom % 6 == 0);
        end
    endtask

    initial begin
        bit want_reset;
        wrst = 1'b0; req = '0; req_data = '0; w_full = 1'b0; almost_full = 1'b0;
        prev_ack = '0;
        want_reset = 0;
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        check_all("reset");
        wrst = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc % 500 == 300) want_reset = 1;
            if (want_reset && m_phase != 0) begin
                want_reset = 0;
                wrst = 1'b0;
                #1;
                chk("midrst.grant", 32'(grant), 32'(0));
                chk("midrst.w_en",  32'(w_en),  32'(0));
                chk("midrst.ack",   32'(ack),   32'(0));
                chk("midrst.busy",  32'(busy),  32'(0));
                model_reset();
                prev_ack = '0;
                @(posedge wclk);
                #1;
                wrst = 1'b1;
            end
            drive(cyc);
            @(negedge wclk);
            check_all("cyc");
            prev_ack = e_ack;
            model_step();
            @(posedge wclk);
            #1;
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
